cc_speedcounter: RTL

Time-base counter that drives the 23-bit count bus consumed by the speed comparator and acts on that comparator's active-low terminal strobe. It increments the bus every clock while running, restarts from zero when the terminal strobe is seen, and emits a one-cycle tick plus a running tick count to the game/display logic. Together with the comparator it forms the programmable-rate time base of the design: the comparator decides *when*, and this block counts and restarts.

---
 rtl/cc_speedcounter.sv | 96 +++++++++
 1 files changed

// File: rtl/cc_speedcounter.sv
// cc_speedcounter: programmable-rate time-base counter with wrap tick and tick count.
// Optional watchdog wrap at all-ones enabled by defining CC_SPEEDCOUNTER_WATCHDOG_EN.
module cc_speedcounter #(
  parameter int SPEEDCOUNTER_DATAWIDTH = 23,
  parameter int SPEEDCOUNTER_TICKWIDTH = 8
) (
  input  logic                              CC_SPEEDCOUNTER_CLOCK_50,
  input  logic                              CC_SPEEDCOUNTER_RESET_InLow,
  input  logic                              CC_SPEEDCOUNTER_enable_InHigh,
  input  logic                              CC_SPEEDCOUNTER_clear_InHigh,
  input  logic                              CC_SPEEDCOUNTER_T0_InLow,
  output logic [SPEEDCOUNTER_DATAWIDTH-1:0] CC_SPEEDCOUNTER_data_OutBUS,
  output logic                              CC_SPEEDCOUNTER_tick_OutHigh,
  output logic [SPEEDCOUNTER_TICKWIDTH-1:0] CC_SPEEDCOUNTER_tickcount_OutBUS,
  output logic                              CC_SPEEDCOUNTER_busy_OutHigh,
  output logic                              CC_SPEEDCOUNTER_error_OutHigh
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t                            state_q, state_d;
  logic [SPEEDCOUNTER_DATAWIDTH-1:0] data_q, data_d;
  logic [SPEEDCOUNTER_TICKWIDTH-1:0] tickcount_q, tickcount_d;
  logic                              tick_q, tick_d;
  logic                              busy_q;
  logic                              error_q, error_d;
  logic                              wd_hit;
`ifdef CC_SPEEDCOUNTER_WATCHDOG_EN
  assign wd_hit = (&data_q) && CC_SPEEDCOUNTER_T0_InLow;
`else
  assign wd_hit = 1'b0;
`endif
  // Next-state logic: clear beats enable/hold, which beats the terminal wrap, which beats increment.
  // A wrap is suppressed right after a tick so tick can never stay high two cycles in a row.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    tick_d      = 1'b0;
    tickcount_d = tickcount_q;
    error_d     = error_q;
    if (CC_SPEEDCOUNTER_clear_InHigh) begin
      state_d     = IDLE;
      data_d      = '0;
      tickcount_d = '0;
      error_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          data_d  = '0;
          state_d = CC_SPEEDCOUNTER_enable_InHigh ? RUN : IDLE;
        end
        RUN: begin
          if (!CC_SPEEDCOUNTER_enable_InHigh) begin
            state_d = HOLD;
          end else if (!CC_SPEEDCOUNTER_T0_InLow) begin
            if (!tick_q) begin
              data_d      = '0;
              tick_d      = 1'b1;
              tickcount_d = tickcount_q + 1'b1;
            end
          end else if (wd_hit) begin
            data_d      = '0;
            tick_d      = 1'b1;
            tickcount_d = tickcount_q + 1'b1;
            error_d     = 1'b1;
          end else begin
            data_d = data_q + 1'b1;
          end
        end
        HOLD:    state_d = CC_SPEEDCOUNTER_enable_InHigh ? RUN : HOLD;
        default: state_d = IDLE;
      endcase
    end
  end
  // State and output registers, all cleared immediately by the async reset.
  always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50 or negedge CC_SPEEDCOUNTER_RESET_InLow) begin
    if (!CC_SPEEDCOUNTER_RESET_InLow) begin
      state_q     <= IDLE;
      data_q      <= '0;
      tick_q      <= 1'b0;
      tickcount_q <= '0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      tick_q      <= tick_d;
      tickcount_q <= tickcount_d;
      busy_q      <= (state_d != IDLE);
      error_q     <= error_d;
    end
  end
  assign CC_SPEEDCOUNTER_data_OutBUS      = data_q;
  assign CC_SPEEDCOUNTER_tick_OutHigh     = tick_q;
  assign CC_SPEEDCOUNTER_tickcount_OutBUS = tickcount_q;
  assign CC_SPEEDCOUNTER_busy_OutHigh     = busy_q;
  assign CC_SPEEDCOUNTER_error_OutHigh    = error_q;
endmodule
